// File: rtl/handshake_reg_slice_if.sv
// Valid/ready handshake bundle around a register slice: m_* is the upstream
// side, s_* the downstream side. The slice takes the slave view, its environment the master view.
interface handshake_reg_slice_if #(
    parameter int unsigned DATA_W = 32
);
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;

    modport master (
        output m_valid, m_data, s_ready,
        input  m_ready, s_valid, s_data
    );

    modport slave (
        input  m_valid, m_data, s_ready,
        output m_ready, s_valid, s_data
    );
endinterface

// File: rtl/handshake_reg_slice.sv
// Valid/ready register slice: bypass, forward (output reg), backward (skid reg)
// or full (skid in front of output reg), selected by MODE at elaboration.
module handshake_reg_slice #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned MODE   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    handshake_reg_slice_if.slave bus,
    output logic [1:0]           occupancy
);

    generate
        if (MODE > 3) begin : g_bad_mode
            $error("handshake_reg_slice: unsupported MODE %0d", MODE);
        end
        if (DATA_W < 1) begin : g_bad_width
            $error("handshake_reg_slice: DATA_W must be at least 1");
        end
    endgenerate

    logic              skid_vld_q, skid_vld_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              out_vld_q, out_vld_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic              m_ready;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              up_xfer;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        out_vld_d   = out_vld_q;
        out_data_d  = out_data_q;
        m_ready     = 1'b1;
        s_valid     = 1'b0;
        s_data      = '0;
        up_xfer     = 1'b0;

        case (MODE)
            0: begin
                m_ready = bus.s_ready;
                s_valid = bus.m_valid;
                s_data  = bus.m_data;
            end
            1: begin
                m_ready = ~out_vld_q | bus.s_ready;
                s_valid = out_vld_q;
                s_data  = out_data_q;
                up_xfer = bus.m_valid & m_ready;
                if (up_xfer) begin
                    out_vld_d  = 1'b1;
                    out_data_d = bus.m_data;
                end else if (out_vld_q && bus.s_ready) begin
                    out_vld_d = 1'b0;
                end
            end
            2: begin
                m_ready = ~skid_vld_q;
                s_valid = skid_vld_q | bus.m_valid;
                s_data  = skid_vld_q ? skid_data_q : bus.m_data;
                up_xfer = bus.m_valid & m_ready;
                if (bus.s_ready) begin
                    skid_vld_d = 1'b0;
                end else if (up_xfer) begin
                    skid_vld_d  = 1'b1;
                    skid_data_d = bus.m_data;
                end
            end
            3: begin
                m_ready = ~skid_vld_q;
                s_valid = out_vld_q;
                s_data  = out_data_q;
                up_xfer = bus.m_valid & m_ready;
                // Output stage refills whenever it is empty or draining; skid only
                // catches the beat that arrives while the output stage is stalled.
                if (!out_vld_q || bus.s_ready) begin
                    if (skid_vld_q) begin
                        out_vld_d  = 1'b1;
                        out_data_d = skid_data_q;
                        skid_vld_d = 1'b0;
                    end else if (up_xfer) begin
                        out_vld_d  = 1'b1;
                        out_data_d = bus.m_data;
                    end else begin
                        out_vld_d = 1'b0;
                    end
                end else if (up_xfer) begin
                    skid_vld_d  = 1'b1;
                    skid_data_d = bus.m_data;
                end
            end
            default: begin
                m_ready = 1'b0;
            end
        endcase
    end

    // NOTE: state updates use <= so every register samples the pre-edge values together.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: payload registers are cleared on reset as well, so discarded beats never reappear.
        if (!rst_n) begin
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
            out_vld_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
            out_vld_q   <= out_vld_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.m_ready = m_ready;
    assign bus.s_valid = s_valid;
    assign bus.s_data  = s_data;
    assign occupancy   = {1'b0, skid_vld_q} + {1'b0, out_vld_q};

endmodule

// File: tb/tb_handshake_reg_slice.sv
// Directed and random checks of all four slice modes, each DUT on its own
// interface instance and driven through per-mode signal vectors.
module tb_handshake_reg_slice;

    localparam int DW = 32;

    logic                clk;
    logic                rst_n;
    logic [3:0]          mv, mr, sv, sr;
    logic [3:0][DW-1:0]  md, sd;
    logic [3:0][1:0]     occ;
    int                  n_cmp;
    int                  n_bad;

    handshake_reg_slice_if #(.DATA_W(DW)) if0 ();
    handshake_reg_slice_if #(.DATA_W(DW)) if1 ();
    handshake_reg_slice_if #(.DATA_W(DW)) if2 ();
    handshake_reg_slice_if #(.DATA_W(DW)) if3 ();

    assign if0.m_valid = mv[0]; assign if0.m_data = md[0]; assign if0.s_ready = sr[0];
    assign if1.m_valid = mv[1]; assign if1.m_data = md[1]; assign if1.s_ready = sr[1];
    assign if2.m_valid = mv[2]; assign if2.m_data = md[2]; assign if2.s_ready = sr[2];
    assign if3.m_valid = mv[3]; assign if3.m_data = md[3]; assign if3.s_ready = sr[3];
    assign mr[0] = if0.m_ready; assign sv[0] = if0.s_valid; assign sd[0] = if0.s_data;
    assign mr[1] = if1.m_ready; assign sv[1] = if1.s_valid; assign sd[1] = if1.s_data;
    assign mr[2] = if2.m_ready; assign sv[2] = if2.s_valid; assign sd[2] = if2.s_data;
    assign mr[3] = if3.m_ready; assign sv[3] = if3.s_valid; assign sd[3] = if3.s_data;

    handshake_reg_slice #(.DATA_W(DW), .MODE(0)) u_mode0 (.clk(clk), .rst_n(rst_n), .bus(if0), .occupancy(occ[0]));
    handshake_reg_slice #(.DATA_W(DW), .MODE(1)) u_mode1 (.clk(clk), .rst_n(rst_n), .bus(if1), .occupancy(occ[1]));
    handshake_reg_slice #(.DATA_W(DW), .MODE(2)) u_mode2 (.clk(clk), .rst_n(rst_n), .bus(if2), .occupancy(occ[2]));
    handshake_reg_slice #(.DATA_W(DW), .MODE(3)) u_mode3 (.clk(clk), .rst_n(rst_n), .bus(if3), .occupancy(occ[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        mv    = '0;
        sr    = '0;
        md    = '0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        mv    = '0;
        sr    = '0;
        md    = '0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (mr[0] !== 1'b0) begin
            n_bad++; $display("FAIL reset_m0_ready_lo: got %b expected 0", mr[0]);
        end
        for (int d = 1; d < 4; d++) begin
            n_cmp++;
            if (sv[d] !== 1'b0) begin
                n_bad++; $display("FAIL reset_s_valid mode%0d: got %b expected 0", d, sv[d]);
            end
            n_cmp++;
            if (mr[d] !== 1'b1) begin
                n_bad++; $display("FAIL reset_m_ready mode%0d: got %b expected 1", d, mr[d]);
            end
            n_cmp++;
            if (occ[d] !== 2'd0) begin
                n_bad++; $display("FAIL reset_occupancy mode%0d: got %0d expected 0", d, occ[d]);
            end
        end
        sr[0] = 1'b1;
        #1;
        n_cmp++;
        if (mr[0] !== 1'b1) begin
            n_bad++; $display("FAIL reset_m0_ready_hi: got %b expected 1", mr[0]);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int d = 1; d < 4; d++) begin
            n_cmp++;
            if (occ[d] !== 2'd0 || sv[d] !== 1'b0) begin
                n_bad++; $display("FAIL reset_held mode%0d: got occ %0d valid %b expected 0 0", d, occ[d], sv[d]);
            end
        end
        sr = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_mode0_comb();
        @(posedge clk); #1;
        mv[0] = 1'b1; md[0] = 32'hDEAD_BEEF; sr[0] = 1'b0;
        #1;
        n_cmp++;
        if (mr[0] !== 1'b0) begin
            n_bad++; $display("FAIL m0_ready_stall: got %b expected 0", mr[0]);
        end
        n_cmp++;
        if (sv[0] !== 1'b1 || sd[0] !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL m0_pass: got %b/%h expected 1/deadbeef", sv[0], sd[0]);
        end
        n_cmp++;
        if (occ[0] !== 2'd0) begin
            n_bad++; $display("FAIL m0_occupancy: got %0d expected 0", occ[0]);
        end
        md[0] = 32'h1234_5678; sr[0] = 1'b1;
        #1;
        n_cmp++;
        if (mr[0] !== 1'b1 || sd[0] !== 32'h1234_5678) begin
            n_bad++; $display("FAIL m0_ready_go: got %b/%h expected 1/12345678", mr[0], sd[0]);
        end
        mv[0] = 1'b0;
        #1;
        n_cmp++;
        if (sv[0] !== 1'b0) begin
            n_bad++; $display("FAIL m0_valid_drop: got %b expected 0", sv[0]);
        end
        sr[0] = 1'b0;
    endtask

    task automatic test_mode1_stream();
        logic exp_v;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            sr[1] = 1'b1;
            mv[1] = (i < 8);
            md[1] = (i < 8) ? 32'(i + 1) : 32'h0;
            @(negedge clk);
            exp_v = (i >= 1 && i <= 8);
            n_cmp++;
            if (mr[1] !== 1'b1) begin
                n_bad++; $display("FAIL m1_ready cyc%0d: got %b expected 1", i, mr[1]);
            end
            n_cmp++;
            if (sv[1] !== exp_v || occ[1] !== {1'b0, exp_v}) begin
                n_bad++; $display("FAIL m1_valid cyc%0d: got %b occ %0d expected %b", i, sv[1], occ[1], exp_v);
            end
            if (exp_v) begin
                n_cmp++;
                if (sd[1] !== 32'(i)) begin
                    n_bad++; $display("FAIL m1_data cyc%0d: got %h expected %h", i, sd[1], 32'(i));
                end
            end
        end
        mv[1] = 1'b0;
    endtask

    task automatic test_mode2_skid();
        do_reset();
        @(posedge clk); #1;
        mv[2] = 1'b1; md[2] = 32'hA5A5_0001; sr[2] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (sv[2] !== 1'b1 || sd[2] !== 32'hA5A5_0001 || mr[2] !== 1'b1) begin
            n_bad++; $display("FAIL m2_first: got v%b d%h r%b expected v1 da5a50001 r1", sv[2], sd[2], mr[2]);
        end
        @(posedge clk); #1;
        md[2] = 32'hA5A5_0002; sr[2] = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (mr[2] !== 1'b0 || occ[2] !== 2'd1) begin
            n_bad++; $display("FAIL m2_skid_full: got r%b occ%0d expected r0 occ1", mr[2], occ[2]);
        end
        n_cmp++;
        if (sv[2] !== 1'b1 || sd[2] !== 32'hA5A5_0001) begin
            n_bad++; $display("FAIL m2_skid_out: got v%b d%h expected v1 da5a50001", sv[2], sd[2]);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (mr[2] !== 1'b1 || occ[2] !== 2'd0 || sd[2] !== 32'hA5A5_0002) begin
            n_bad++; $display("FAIL m2_drained: got r%b occ%0d d%h expected r1 occ0 da5a50002", mr[2], occ[2], sd[2]);
        end
        @(posedge clk); #1;
        mv[2] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (sv[2] !== 1'b0 || mr[2] !== 1'b1) begin
            n_bad++; $display("FAIL m2_idle: got v%b r%b expected v0 r1", sv[2], mr[2]);
        end
        sr[2] = 1'b0;
    endtask

    task automatic test_mode3_backpressure();
        int in_i;
        int out_i;
        logic r0, v0, s0, m0;
        logic [DW-1:0] d0, md0;
        do_reset();
        in_i  = 0;
        out_i = 0;
        for (int cyc = 0; cyc < 200 && out_i < 16; cyc++) begin
            @(posedge clk); #1;
            mv[3] = (in_i < 16);
            md[3] = 32'h10 + 32'(in_i);
            sr[3] = (cyc % 4 == 0) || (cyc % 4 == 3);
            @(negedge clk);
            n_cmp++;
            if (occ[3] > 2'd2) begin
                n_bad++; $display("FAIL m3_occ_max cyc%0d: got %0d expected <=2", cyc, occ[3]);
            end
            r0 = mr[3]; v0 = sv[3]; d0 = sd[3];
            s0 = sr[3]; m0 = mv[3]; md0 = md[3];
            sr[3] = ~s0; mv[3] = ~m0; md[3] = ~md0;
            #1;
            n_cmp++;
            if (mr[3] !== r0 || sv[3] !== v0 || sd[3] !== d0) begin
                n_bad++; $display("FAIL m3_comb_path cyc%0d: got r%b v%b d%h expected r%b v%b d%h", cyc, mr[3], sv[3], sd[3], r0, v0, d0);
            end
            sr[3] = s0; mv[3] = m0; md[3] = md0;
            #1;
            if (mv[3] && mr[3]) in_i++;
            if (sv[3] && sr[3]) begin
                n_cmp++;
                if (sd[3] !== 32'h10 + 32'(out_i)) begin
                    n_bad++; $display("FAIL m3_order beat%0d: got %h expected %h", out_i, sd[3], 32'h10 + 32'(out_i));
                end
                out_i++;
            end
        end
        n_cmp++;
        if (out_i != 16) begin
            n_bad++; $display("FAIL m3_bp_done: got %0d beats expected 16", out_i);
        end
        mv[3] = 1'b0; sr[3] = 1'b0;
    endtask

    task automatic test_mode3_full_rate();
        logic exp_v;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            sr[3] = 1'b1;
            mv[3] = (i < 8);
            md[3] = 32'h20 + 32'(i);
            @(negedge clk);
            exp_v = (i >= 1 && i <= 8);
            n_cmp++;
            if (mr[3] !== 1'b1 || occ[3] !== {1'b0, exp_v}) begin
                n_bad++; $display("FAIL m3_rate_skid cyc%0d: got r%b occ%0d expected r1 occ%0d", i, mr[3], occ[3], exp_v);
            end
            n_cmp++;
            if (sv[3] !== exp_v || (exp_v && sd[3] !== 32'h1F + 32'(i))) begin
                n_bad++; $display("FAIL m3_rate_out cyc%0d: got v%b d%h expected v%b d%h", i, sv[3], sd[3], exp_v, 32'h1F + 32'(i));
            end
        end
        mv[3] = 1'b0; sr[3] = 1'b0;
    endtask

    task automatic test_mode3_reset_mid();
        do_reset();
        @(posedge clk); #1;
        mv[3] = 1'b1; md[3] = 32'hAA; sr[3] = 1'b0;
        @(posedge clk); #1;
        md[3] = 32'hBB;
        @(posedge clk); #1;
        mv[3] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (occ[3] !== 2'd2 || mr[3] !== 1'b0 || sd[3] !== 32'hAA) begin
            n_bad++; $display("FAIL m3_fill: got occ%0d r%b d%h expected occ2 r0 daa", occ[3], mr[3], sd[3]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (sv[3] !== 1'b0 || occ[3] !== 2'd0 || mr[3] !== 1'b1) begin
            n_bad++; $display("FAIL m3_async_rst: got v%b occ%0d r%b expected v0 occ0 r1", sv[3], occ[3], mr[3]);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        mv[3] = 1'b1; md[3] = 32'h55; sr[3] = 1'b1;
        @(posedge clk); #1;
        mv[3] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (sv[3] !== 1'b1 || sd[3] !== 32'h55) begin
            n_bad++; $display("FAIL m3_first_after_rst: got v%b d%h expected v1 d55", sv[3], sd[3]);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (sv[3] !== 1'b0 || occ[3] !== 2'd0) begin
            n_bad++; $display("FAIL m3_no_stale: got v%b occ%0d expected v0 occ0", sv[3], occ[3]);
        end
        sr[3] = 1'b0;
    endtask

    task automatic test_random();
        int in_cnt [4];
        int out_cnt [4];
        logic hold [4];
        logic [DW-1:0] held [4];
        logic [DW-1:0] exp_d;
        bit done;
        do_reset();
        for (int d = 0; d < 4; d++) begin
            in_cnt[d] = 0; out_cnt[d] = 0; hold[d] = 1'b0; held[d] = '0;
        end
        for (int cyc = 0; cyc < 50000; cyc++) begin
            done = 1'b1;
            for (int d = 0; d < 4; d++) if (out_cnt[d] < 10000) done = 1'b0;
            if (done) break;
            @(posedge clk); #1;
            for (int d = 0; d < 4; d++) begin
                mv[d] = 1'($urandom_range(0, 1));
                sr[d] = 1'($urandom_range(0, 1));
                md[d] = (32'(d) << 28) | 32'(in_cnt[d]);
            end
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                if (d != 0 && hold[d]) begin
                    n_cmp++;
                    if (sv[d] !== 1'b1 || sd[d] !== held[d]) begin
                        n_bad++; $display("FAIL rnd_stable mode%0d cyc%0d: got v%b d%h expected v1 d%h", d, cyc, sv[d], sd[d], held[d]);
                    end
                end
                if (mv[d] && mr[d]) in_cnt[d]++;
                if (sv[d] && sr[d]) begin
                    exp_d = (32'(d) << 28) | 32'(out_cnt[d]);
                    n_cmp++;
                    if (sd[d] !== exp_d) begin
                        n_bad++; $display("FAIL rnd_order mode%0d beat%0d: got %h expected %h", d, out_cnt[d], sd[d], exp_d);
                    end
                    out_cnt[d]++;
                end
                hold[d] = sv[d] & ~sr[d];
                held[d] = sd[d];
            end
        end
        for (int d = 0; d < 4; d++) begin
            n_cmp++;
            if (out_cnt[d] < 10000) begin
                n_bad++; $display("FAIL rnd_done mode%0d: got %0d beats expected 10000", d, out_cnt[d]);
            end
        end
        mv = '0; sr = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_mode0_comb();
        test_mode1_stream();
        test_mode2_skid();
        test_mode3_backpressure();
        test_mode3_full_rate();
        test_mode3_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
